decode_stage: RTL
=================

Name: decode_stage

Overview:
Registered, flow-controlled RV32I/Zicsr instruction decode stage. It sits between the fetch stage and the execute stage. It accepts one instruction word plus PC per handshake and emits one decoded bundle per handshake: instruction ID, register indices, immediate sign-extended to XLEN, shift amount, and an illegal flag. A 2-entry skid buffer decouples back-pressure, so ready is never combinationally dependent on downstream ready, and flush support is included.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN; shift amount is $clog2(XLEN) bits.
ID_W, 6, width of the instruction-ID field; ID value all-ones = ID_INVALID.
EN_CSR, 1, 1 = decode csrrw/csrrs/csrrc/csrrwi/csrrsi/csrrci; 0 = these decode as illegal.
PC_W, 32, width of the PC passthrough.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and in-flight entries
in_valid  in  1  fetch presents instr/pc
in_ready  out  1  stage can accept (registered)
in_instr  in  32  raw instruction word
in_pc  in  PC_W  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  PC_W  PC of bundle
out_id  out  ID_W  instruction ID (package enum)
out_rd/out_rs1/out_rs2  out  5 each  register indices
out_func3  out  3  instr[14:12]
out_func7  out  7  instr[31:25]
out_imm  out  XLEN  format-correct sign-extended immediate
out_shamt  out  $clog2(XLEN)  instr[20+:$clog2(XLEN)]
out_illegal  out  1  unrecognised or reserved encoding

Behaviour:
- Reset (async assert, sync deassert by the environment): out_valid=0, in_ready=1, out_id=ID_INVALID, out_illegal=0; all other outputs 0; state EMPTY.
- Decode is combinational on the incoming word; the result is registered. Latency is 1 cycle from accepted input to out_valid.
- Accept when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
- FSM with 3 states:
  - EMPTY: in_ready=1, out_valid=0. Accept moves to FULL.
  - FULL: output register holds a bundle, in_ready=1.
    - Accept+transfer: stay FULL with the new bundle.
    - Transfer only: go to EMPTY.
    - Accept without transfer: the bundle goes into the skid register; go to SKID.
  - SKID: in_ready=0. On transfer, the skid bundle moves to the output register; go to FULL.
- Ordering is strictly FIFO. No bundle is dropped or duplicated.
- flush has priority over all events in its cycle. Next state is EMPTY, out_valid=0, in_ready=1. An input presented in the flush cycle is discarded even if in_ready=1.
- Output fields are stable while out_valid=1 and out_ready=0.
- Immediate formats, each sign-extended from bit 31 to XLEN:
  - I: [31:20]
  - S: [31:25],[11:7]
  - B: [31],[7],[30:25],[11:8],0
  - U: [31:12],12'b0
  - J: [31],[19:12],[20],[30:21],0
  - R-type: immediate is 0.
- Illegal (out_illegal=1, out_id=ID_INVALID):
  - Unknown opcode.
  - Unused func3 for load, store or branch.
  - R-type func7 not in {0000000, 0100000}, or 0100000 with func3 other than 000 or 101.
  - slli with func7≠0; srli/srai with func7 not in {0000000, 0100000}.
  - SYSTEM func3=000 with a word other than 0x00000073 (ecall) or 0x00100073 (ebreak).
  - CSR ops when EN_CSR=0.
- out_illegal travels with its bundle and obeys the same handshake. The stage does not trap.
- Exactly one ID is produced per instruction. Format decode is a single priority-free case on opcode, with a single driver per field.

Decomposition:
- Package decode_pkg holds:
  - Enum instr_id_e, ID_W wide, covering lui, auipc, jal, jalr, 6 branches, 5 loads, 3 stores, 9 OP-IMM, 10 OP, 6 CSR, ecall, ebreak, plus ID_INVALID = all-ones.
  - Opcode constants OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH, OPC_STORE, OPC_OP.
  - Packed struct decoded_t holding the bundle.
- Sub-module decode_comb is purely combinational: instr → decoded_t, with no state. decode_stage instantiates it once and owns the FSM, the output register and the skid register.

Test Plan:
- Reset, then 0x00500093 with out_ready=1 → next cycle out_valid=1, id=ADDI, rd=1, rs1=0, imm=5, illegal=0.
- 0xFE000EE3 (beq x0,x0,-4) → id=BEQ, imm=0xFFFFFFFC (XLEN=32) or 0xFFFFFFFFFFFFFFFC (XLEN=64); 0x123452B7 → id=LUI, rd=5, imm=0x12345000.
- 0x00000073 → ECALL; 0x00100073 → EBREAK; 0xFFFFFFFF → illegal=1, id=ID_INVALID; 0x02000033 (func7=0000001) → illegal=1; with EN_CSR=0, 0x30029073 → illegal=1.
- Back-pressure: stream 4 distinct instructions while out_ready=0 → in_ready drops after the 2nd accept, only 2 are accepted; then raise out_ready → bundles emerge in order, one per cycle, none lost.
- Flush while in SKID state, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1; the flushed and the concurrent inputs never appear.
- Assert rst_n=0 asynchronously mid-stream, between clock edges → out_valid=0 and in_ready=1 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the RV32I/Zicsr decode stage: instruction IDs, opcodes,
// the decoded bundle layout and the stage FSM states.
package decode_pkg;

   localparam int INSTR_ID_W = 6;
   localparam int IMM_MAX_W  = 64;
   localparam int SHAMT_MAX_W = 6;

   typedef enum logic [INSTR_ID_W-1:0] {
      ID_LUI, ID_AUIPC, ID_JAL, ID_JALR,
      ID_BEQ, ID_BNE, ID_BLT, ID_BGE, ID_BLTU, ID_BGEU,
      ID_LB, ID_LH, ID_LW, ID_LBU, ID_LHU,
      ID_SB, ID_SH, ID_SW,
      ID_ADDI, ID_SLTI, ID_SLTIU, ID_XORI, ID_ORI, ID_ANDI, ID_SLLI, ID_SRLI, ID_SRAI,
      ID_ADD, ID_SUB, ID_SLL, ID_SLT, ID_SLTU, ID_XOR, ID_SRL, ID_SRA, ID_OR, ID_AND,
      ID_CSRRW, ID_CSRRS, ID_CSRRC, ID_CSRRWI, ID_CSRRSI, ID_CSRRCI,
      ID_ECALL, ID_EBREAK,
      ID_INVALID = 6'h3F
   } instr_id_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Immediate and shift amount are kept at the widest XLEN; the stage
   // slices them down to its own XLEN at the output.
   typedef struct packed {
      instr_id_e              id;
      logic [4:0]             rd;
      logic [4:0]             rs1;
      logic [4:0]             rs2;
      logic [2:0]             func3;
      logic [6:0]             func7;
      logic [IMM_MAX_W-1:0]   imm;
      logic [SHAMT_MAX_W-1:0] shamt;
      logic                   illegal;
   } decoded_t;

   localparam decoded_t DECODED_RESET = '{
      id: ID_INVALID, rd: '0, rs1: '0, rs2: '0, func3: '0,
      func7: '0, imm: '0, shamt: '0, illegal: 1'b0
   };

   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} stage_state_e;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Handshake: a beat moves on a rising clk edge where valid && ready are both
// high; the sender holds its payload stable while valid is high and ready low,
// and ready never depends combinationally on valid.
interface decode_stage_if #(
   parameter int XLEN = 32,
   parameter int ID_W = 6,
   parameter int PC_W = 32
);
   localparam int SHW = $clog2(XLEN);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [PC_W-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [ID_W-1:0] out_id;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic [2:0]      out_func3;
   logic [6:0]      out_func7;
   logic [XLEN-1:0] out_imm;
   logic [SHW-1:0]  out_shamt;
   logic            out_illegal;

   // Environment side: fetch drives instructions, execute drives out_ready.
   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_id, out_rd, out_rs1, out_rs2,
             out_func3, out_func7, out_imm, out_shamt, out_illegal
   );

   // Decode stage side.
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_id, out_rd, out_rs1, out_rs2,
             out_func3, out_func7, out_imm, out_shamt, out_illegal
   );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I/Zicsr decoder: instruction word in, bundle out.
import decode_pkg::*;

module decode_comb #(
   parameter bit EN_CSR = 1'b1
) (
   input  logic [31:0] instr,
   output decoded_t    dec
);
   logic [6:0]           opc;
   logic [2:0]           f3;
   logic [6:0]           f7;
   logic [IMM_MAX_W-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   instr_id_e            id_c;
   logic [IMM_MAX_W-1:0] imm_c;

   assign opc = instr[6:0];
   assign f3  = instr[14:12];
   assign f7  = instr[31:25];

   assign imm_i = {{52{instr[31]}}, instr[31:20]};
   assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // One case on opcode picks both the instruction ID and the immediate format.
   always_comb begin
      id_c  = ID_INVALID;
      imm_c = '0;
      case (opc)
         OPC_LUI:   begin id_c = ID_LUI;   imm_c = imm_u; end
         OPC_AUIPC: begin id_c = ID_AUIPC; imm_c = imm_u; end
         OPC_JAL:   begin id_c = ID_JAL;   imm_c = imm_j; end
         OPC_JALR:  begin id_c = ID_JALR;  imm_c = imm_i; end
         OPC_BRANCH: begin
            imm_c = imm_b;
            case (f3)
               3'b000:  id_c = ID_BEQ;
               3'b001:  id_c = ID_BNE;
               3'b100:  id_c = ID_BLT;
               3'b101:  id_c = ID_BGE;
               3'b110:  id_c = ID_BLTU;
               3'b111:  id_c = ID_BGEU;
               default: ;
            endcase
         end
         OPC_LOAD: begin
            imm_c = imm_i;
            case (f3)
               3'b000:  id_c = ID_LB;
               3'b001:  id_c = ID_LH;
               3'b010:  id_c = ID_LW;
               3'b100:  id_c = ID_LBU;
               3'b101:  id_c = ID_LHU;
               default: ;
            endcase
         end
         OPC_STORE: begin
            imm_c = imm_s;
            case (f3)
               3'b000:  id_c = ID_SB;
               3'b001:  id_c = ID_SH;
               3'b010:  id_c = ID_SW;
               default: ;
            endcase
         end
         OPC_OPIMM: begin
            imm_c = imm_i;
            case (f3)
               3'b000:  id_c = ID_ADDI;
               3'b010:  id_c = ID_SLTI;
               3'b011:  id_c = ID_SLTIU;
               3'b100:  id_c = ID_XORI;
               3'b110:  id_c = ID_ORI;
               3'b111:  id_c = ID_ANDI;
               3'b001:  if (f7 == 7'b0000000) id_c = ID_SLLI;
               default: begin
                  if (f7 == 7'b0000000)      id_c = ID_SRLI;
                  else if (f7 == 7'b0100000) id_c = ID_SRAI;
               end
            endcase
         end
         OPC_OP: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  id_c = ID_ADD;
                  3'b001:  id_c = ID_SLL;
                  3'b010:  id_c = ID_SLT;
                  3'b011:  id_c = ID_SLTU;
                  3'b100:  id_c = ID_XOR;
                  3'b101:  id_c = ID_SRL;
                  3'b110:  id_c = ID_OR;
                  default: id_c = ID_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               if (f3 == 3'b000)      id_c = ID_SUB;
               else if (f3 == 3'b101) id_c = ID_SRA;
            end
         end
         OPC_SYSTEM: begin
            imm_c = imm_i;
            case (f3)
               3'b000: begin
                  if (instr == 32'h0000_0073)      id_c = ID_ECALL;
                  else if (instr == 32'h0010_0073) id_c = ID_EBREAK;
               end
               3'b001:  if (EN_CSR) id_c = ID_CSRRW;
               3'b010:  if (EN_CSR) id_c = ID_CSRRS;
               3'b011:  if (EN_CSR) id_c = ID_CSRRC;
               3'b101:  if (EN_CSR) id_c = ID_CSRRWI;
               3'b110:  if (EN_CSR) id_c = ID_CSRRSI;
               3'b111:  if (EN_CSR) id_c = ID_CSRRCI;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign dec = '{
      id:      id_c,
      rd:      instr[11:7],
      rs1:     instr[19:15],
      rs2:     instr[24:20],
      func3:   f3,
      func7:   f7,
      imm:     imm_c,
      shamt:   instr[25:20],
      illegal: (id_c == ID_INVALID)
   };

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a one-entry skid register behind the output
// register, so in_ready is a flop and never follows out_ready combinationally.
import decode_pkg::*;

module decode_stage #(
   parameter int XLEN   = 32,
   parameter int ID_W   = 6,
   parameter bit EN_CSR = 1'b1,
   parameter int PC_W   = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   decode_stage_if.slave  bus,
   output stage_state_e   state_dbg
);
   localparam int SHW = $clog2(XLEN);

   decoded_t        dec;
   decoded_t        out_q, skid_q;
   logic [PC_W-1:0] out_pc_q, skid_pc_q;
   logic            in_ready_q, out_valid_q;
   stage_state_e    state_q;
   logic            accept, transfer;

   decode_comb #(.EN_CSR(EN_CSR)) u_decode_comb (
      .instr (bus.in_instr),
      .dec   (dec)
   );

   assign accept   = bus.in_valid && in_ready_q;
   assign transfer = out_valid_q && bus.out_ready;

   // EMPTY/FULL/SKID control with registered in_ready/out_valid; flush wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= DECODED_RESET;
         skid_q      <= DECODED_RESET;
         out_pc_q    <= '0;
         skid_pc_q   <= '0;
      end else if (flush) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  out_q       <= dec;
                  out_pc_q    <= bus.in_pc;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (accept && transfer) begin
                  out_q    <= dec;
                  out_pc_q <= bus.in_pc;
               end else if (transfer) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_EMPTY;
               end else if (accept) begin
                  skid_q     <= dec;
                  skid_pc_q  <= bus.in_pc;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_SKID;
               end
            end
            default: begin
               if (transfer) begin
                  out_q      <= skid_q;
                  out_pc_q   <= skid_pc_q;
                  in_ready_q <= 1'b1;
                  state_q    <= ST_FULL;
               end
            end
         endcase
      end
   end

   assign state_dbg       = state_q;
   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_pc      = out_pc_q;
   assign bus.out_id      = ID_W'(out_q.id);
   assign bus.out_rd      = out_q.rd;
   assign bus.out_rs1     = out_q.rs1;
   assign bus.out_rs2     = out_q.rs2;
   assign bus.out_func3   = out_q.func3;
   assign bus.out_func7   = out_q.func7;
   assign bus.out_imm     = out_q.imm[XLEN-1:0];
   assign bus.out_shamt   = out_q.shamt[SHW-1:0];
   assign bus.out_illegal = out_q.illegal;

   // Upper immediate/shamt bits are only consumed when XLEN is 64.
   logic unused_wide_bits;
   assign unused_wide_bits = ^out_q;

endmodule
